// File: rtl/mem_stage_pkg.sv
// ============================================================================
//  Module   : mem_stage_pkg
//  Purpose  : Shared types, funct3 encodings and lane helpers for mem_stage.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_stage_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_e;

  function automatic logic [7:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'd0:    return 8'h01;
      2'd1:    return 8'h03;
      2'd2:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  // Byte offset rounded down to the natural alignment of the access size.
  function automatic logic [2:0] align_off(input logic [2:0] off, input logic [1:0] sz);
    case (sz)
      2'd0:    return off;
      2'd1:    return {off[2:1], 1'b0};
      2'd2:    return {off[2], 2'b00};
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] off, input logic [1:0] sz);
    return off != align_off(off, sz);
  endfunction

  function automatic logic f3_defined(input logic is_load, input logic [2:0] f3);
    return is_load ? (f3 != 3'b111) : !f3[2];
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_stage_lane_align.sv
// ============================================================================
//  Module   : mem_stage_lane_align
//  Purpose  : Byte-lane steering: store strobes/data and load extraction.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_stage_lane_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [2:0]  off,
  input  logic [63:0] wdata,
  input  logic [63:0] rdata,
  output logic [7:0]  wstrb,
  output logic [63:0] wdata_sh,
  output logic [63:0] rdata_ext
);

  logic [2:0]  w_off;
  logic [63:0] w_d;

  always_comb begin
    // Clearing sub-size bits keeps a misaligned access inside its natural slot.
    w_off    = align_off(off, funct3[1:0]);
    wstrb    = size_mask(funct3[1:0]) << w_off;
    wdata_sh = wdata << {w_off, 3'b000};
    w_d      = rdata >> {w_off, 3'b000};
    case (funct3)
      F3_B:    rdata_ext = {{56{w_d[7]}},  w_d[7:0]};
      F3_H:    rdata_ext = {{48{w_d[15]}}, w_d[15:0]};
      F3_W:    rdata_ext = {{32{w_d[31]}}, w_d[31:0]};
      F3_BU:   rdata_ext = {56'd0, w_d[7:0]};
      F3_HU:   rdata_ext = {48'd0, w_d[15:0]};
      F3_WU:   rdata_ext = {32'd0, w_d[31:0]};
      default: rdata_ext = w_d;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_stage.sv
// ============================================================================
//  Module   : mem_stage
//  Purpose  : Memory-access pipeline stage with one valid/ready bus access per
//             load/store. Define MEM_MISALIGN_TRAP_EN to trap misaligned ops.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int XLEN           = 64,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic            ex_load,
  input  logic            ex_store,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] ex_addr,
  input  logic [XLEN-1:0] ex_wdata,
  input  logic [XLEN-1:0] ex_alu_result,
  input  logic            ex_rd_w_ena,
  input  logic [4:0]      ex_rd_w_addr,
  output logic            dmem_req_valid,
  input  logic            dmem_req_ready,
  output logic [XLEN-1:0] dmem_req_addr,
  output logic            dmem_req_we,
  output logic [XLEN-1:0] dmem_req_wdata,
  output logic [7:0]      dmem_req_wstrb,
  input  logic            dmem_rsp_valid,
  input  logic [XLEN-1:0] dmem_rsp_rdata,
  output logic            wb_valid,
  output logic            wb_rd_w_ena,
  output logic [4:0]      wb_rd_w_addr,
  output logic [XLEN-1:0] wb_rd_data,
  output logic            wb_err
);

  localparam int             CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              is_load_q, is_load_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic              rd_w_ena_q, rd_w_ena_d;
  logic [4:0]        rd_w_addr_q, rd_w_addr_d;
  logic              wb_valid_q, wb_valid_d;
  logic              wb_rd_w_ena_q, wb_rd_w_ena_d;
  logic [4:0]        wb_rd_w_addr_q, wb_rd_w_addr_d;
  logic [XLEN-1:0]   wb_rd_data_q, wb_rd_data_d;
  logic              wb_err_q, wb_err_d;

  logic              w_mem_op;
  logic              w_in_req;
  logic [7:0]        w_lane_wstrb;
  logic [XLEN-1:0]   w_lane_wdata;
  logic [XLEN-1:0]   w_lane_rdata;

  mem_stage_lane_align u_lane_align (
    .funct3    (funct3_q),
    .off       (addr_q[2:0]),
    .wdata     (wdata_q),
    .rdata     (dmem_rsp_rdata),
    .wstrb     (w_lane_wstrb),
    .wdata_sh  (w_lane_wdata),
    .rdata_ext (w_lane_rdata)
  );

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    is_load_d      = is_load_q;
    funct3_d       = funct3_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    rd_w_ena_d     = rd_w_ena_q;
    rd_w_addr_d    = rd_w_addr_q;
    wb_valid_d     = 1'b0;
    wb_rd_w_ena_d  = 1'b0;
    wb_rd_w_addr_d = 5'd0;
    wb_rd_data_d   = '0;
    wb_err_d       = 1'b0;
    w_mem_op       = ex_load | ex_store;

    case (state_q)
      S_IDLE: begin
        if (ex_valid) begin
          is_load_d   = ex_load;
          funct3_d    = ex_funct3;
          addr_d      = ex_addr;
          wdata_d     = ex_wdata;
          rd_w_ena_d  = ex_rd_w_ena;
          rd_w_addr_d = ex_rd_w_addr;
          if (w_mem_op && f3_defined(ex_load, ex_funct3)) begin
`ifdef MEM_MISALIGN_TRAP_EN
            if (is_misaligned(ex_addr[2:0], ex_funct3[1:0])) begin
              state_d        = S_RESP;
              wb_valid_d     = 1'b1;
              wb_err_d       = 1'b1;
              wb_rd_w_addr_d = ex_rd_w_addr;
            end else begin
              state_d = S_REQ;
            end
`else
            state_d = S_REQ;
`endif
          end else begin
            // Plain ALU ops, and memory ops with a reserved funct3 (never written back).
            state_d        = S_RESP;
            wb_valid_d     = 1'b1;
            wb_rd_w_ena_d  = !w_mem_op && ex_rd_w_ena && (ex_rd_w_addr != 5'd0);
            wb_rd_w_addr_d = ex_rd_w_addr;
            wb_rd_data_d   = ex_alu_result;
          end
        end
      end
      S_REQ: begin
        if (dmem_req_ready) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        if (dmem_rsp_valid) begin
          state_d        = S_RESP;
          wb_valid_d     = 1'b1;
          wb_rd_w_addr_d = rd_w_addr_q;
          if (is_load_q) begin
            wb_rd_w_ena_d = rd_w_ena_q && (rd_w_addr_q != 5'd0);
            wb_rd_data_d  = w_lane_rdata;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d        = S_RESP;
          wb_valid_d     = 1'b1;
          wb_err_d       = 1'b1;
          wb_rd_w_addr_d = rd_w_addr_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      is_load_q      <= 1'b0;
      funct3_q       <= 3'd0;
      addr_q         <= '0;
      wdata_q        <= '0;
      rd_w_ena_q     <= 1'b0;
      rd_w_addr_q    <= 5'd0;
      wb_valid_q     <= 1'b0;
      wb_rd_w_ena_q  <= 1'b0;
      wb_rd_w_addr_q <= 5'd0;
      wb_rd_data_q   <= '0;
      wb_err_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      is_load_q      <= is_load_d;
      funct3_q       <= funct3_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      rd_w_ena_q     <= rd_w_ena_d;
      rd_w_addr_q    <= rd_w_addr_d;
      wb_valid_q     <= wb_valid_d;
      wb_rd_w_ena_q  <= wb_rd_w_ena_d;
      wb_rd_w_addr_q <= wb_rd_w_addr_d;
      wb_rd_data_q   <= wb_rd_data_d;
      wb_err_q       <= wb_err_d;
    end
  end

  // Request fields come straight from captured state, so they hold while stalled.
  assign w_in_req       = (state_q == S_REQ);
  assign ex_ready       = (state_q == S_IDLE);
  assign dmem_req_valid = w_in_req;
  assign dmem_req_addr  = w_in_req ? {addr_q[XLEN-1:3], 3'b000} : '0;
  assign dmem_req_we    = w_in_req && !is_load_q;
  assign dmem_req_wdata = (w_in_req && !is_load_q) ? w_lane_wdata : '0;
  assign dmem_req_wstrb = (w_in_req && !is_load_q) ? w_lane_wstrb : 8'd0;

  assign wb_valid     = wb_valid_q;
  assign wb_rd_w_ena  = wb_rd_w_ena_q;
  assign wb_rd_w_addr = wb_rd_w_addr_q;
  assign wb_rd_data   = wb_rd_data_q;
  assign wb_err       = wb_err_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ============================================================================
//  Module   : tb_mem_stage
//  Purpose  : Directed vector table plus stall/timeout/reset sequences.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_ready, ex_load, ex_store, ex_rd_w_ena;
  logic [2:0]  ex_funct3;
  logic [63:0] ex_addr, ex_wdata, ex_alu_result;
  logic [4:0]  ex_rd_w_addr;
  logic        dmem_req_valid, dmem_req_ready, dmem_req_we, dmem_rsp_valid;
  logic [63:0] dmem_req_addr, dmem_req_wdata, dmem_rsp_rdata;
  logic [7:0]  dmem_req_wstrb;
  logic        wb_valid, wb_rd_w_ena, wb_err;
  logic [4:0]  wb_rd_w_addr;
  logic [63:0] wb_rd_data;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_stage #(.XLEN(64), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_load(ex_load), .ex_store(ex_store),
    .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
    .ex_alu_result(ex_alu_result), .ex_rd_w_ena(ex_rd_w_ena), .ex_rd_w_addr(ex_rd_w_addr),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_req_addr(dmem_req_addr), .dmem_req_we(dmem_req_we),
    .dmem_req_wdata(dmem_req_wdata), .dmem_req_wstrb(dmem_req_wstrb),
    .dmem_rsp_valid(dmem_rsp_valid), .dmem_rsp_rdata(dmem_rsp_rdata),
    .wb_valid(wb_valid), .wb_rd_w_ena(wb_rd_w_ena), .wb_rd_w_addr(wb_rd_w_addr),
    .wb_rd_data(wb_rd_data), .wb_err(wb_err)
  );

  typedef struct {
    logic        ld, st;
    logic [2:0]  f3;
    logic [63:0] addr, wdata, alu, rdata;
    logic        rd_ena;
    logic [4:0]  rd;
    logic        mem;
    logic [63:0] req_addr;
    logic [7:0]  strb;
    logic [63:0] bus_wdata;
    logic        wb_ena, chk_data;
    logic [63:0] wb_data;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=0x%016h required=0x%016h", name, act, exp);
    end
  endtask

  function automatic void add_vec(
    input logic ld, input logic st, input logic [2:0] f3, input logic [63:0] addr,
    input logic [63:0] wdata, input logic [63:0] alu, input logic [63:0] rdata,
    input logic rd_ena, input logic [4:0] rd, input logic mem, input logic [63:0] req_addr,
    input logic [7:0] strb, input logic [63:0] bus_wdata, input logic wb_ena,
    input logic chk_data, input logic [63:0] wb_data, input logic err, input int lat);
    vec_t v;
    v.ld = ld; v.st = st; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.alu = alu;
    v.rdata = rdata; v.rd_ena = rd_ena; v.rd = rd; v.mem = mem; v.req_addr = req_addr;
    v.strb = strb; v.bus_wdata = bus_wdata; v.wb_ena = wb_ena; v.chk_data = chk_data;
    v.wb_data = wb_data; v.err = err; v.lat = lat;
    vecs.push_back(v);
  endfunction

  task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [63:0] addr, input logic [63:0] wdata,
                       input logic [63:0] alu, input logic rd_ena, input logic [4:0] rd);
    @(negedge clk);
    ex_valid = 1'b1; ex_load = ld; ex_store = st; ex_funct3 = f3; ex_addr = addr;
    ex_wdata = wdata; ex_alu_result = alu; ex_rd_w_ena = rd_ena; ex_rd_w_addr = rd;
    @(negedge clk);
    ex_valid = 1'b0;
  endtask

  // Bus answers instantly; the response is held so it also lands outside WAIT.
  task automatic run_vec(input int idx, input vec_t v);
    int  n = 1;
    bit  seen_req = 0;
    bit  done = 0;
    dmem_req_ready = 1'b1; dmem_rsp_valid = 1'b1; dmem_rsp_rdata = v.rdata;
    issue(v.ld, v.st, v.f3, v.addr, v.wdata, v.alu, v.rd_ena, v.rd);
    while (!done && n <= 10) begin
      if (dmem_req_valid && !seen_req) begin
        seen_req = 1;
        check($sformatf("v%0d req_addr", idx), dmem_req_addr, v.req_addr);
        check($sformatf("v%0d req_we", idx), 64'(dmem_req_we), 64'(v.st && !v.ld));
        if (v.st && !v.ld) begin
          check($sformatf("v%0d req_wstrb", idx), 64'(dmem_req_wstrb), 64'(v.strb));
          check($sformatf("v%0d req_wdata", idx), dmem_req_wdata, v.bus_wdata);
        end
      end
      if (wb_valid) begin
        done = 1;
        check($sformatf("v%0d latency", idx), 64'(n), 64'(v.lat));
        check($sformatf("v%0d wb_err", idx), 64'(wb_err), 64'(v.err));
        check($sformatf("v%0d wb_rd_w_ena", idx), 64'(wb_rd_w_ena), 64'(v.wb_ena));
        if (v.wb_ena) check($sformatf("v%0d wb_rd_w_addr", idx), 64'(wb_rd_w_addr), 64'(v.rd));
        if (v.chk_data) check($sformatf("v%0d wb_rd_data", idx), wb_rd_data, v.wb_data);
      end else begin
        @(negedge clk);
        n++;
      end
    end
    if (!done) check($sformatf("v%0d wb_valid timeout", idx), 64'd0, 64'd1);
    check($sformatf("v%0d bus_used", idx), 64'(seen_req), 64'(v.mem));
    @(negedge clk);
    check($sformatf("v%0d wb_one_cycle", idx), 64'(wb_valid), 64'd0);
    check($sformatf("v%0d ex_ready_after", idx), 64'(ex_ready), 64'd1);
    dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0;
  endtask

  initial begin
    int first_wb;
    rst = 1'b1; ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0; ex_funct3 = 3'd0;
    ex_addr = '0; ex_wdata = '0; ex_alu_result = '0; ex_rd_w_ena = 1'b0; ex_rd_w_addr = 5'd0;
    dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0; dmem_rsp_rdata = '0;
    repeat (3) @(negedge clk);
    check("reset ex_ready", 64'(ex_ready), 64'd1);
    check("reset req_valid", 64'(dmem_req_valid), 64'd0);
    check("reset wb_valid", 64'(wb_valid), 64'd0);
    check("reset wb_err", 64'(wb_err), 64'd0);
    check("reset wb_rd_w_ena", 64'(wb_rd_w_ena), 64'd0);
    check("reset wb_rd_data", wb_rd_data, 64'd0);
    rst = 1'b0;

    //       ld st f3      addr         wdata                  alu       rdata                  en rd mem req_addr  strb   bus_wdata              wbe chk wb_data                err lat
    add_vec(0, 0, 3'b000, 64'h0,      64'h0,                 64'h1234, 64'h0,                 1, 5, 0, 64'h0,    8'h00, 64'h0,                 1, 1, 64'h1234,               0, 1);
    add_vec(1, 0, 3'b000, 64'h1003,   64'h0,                 64'h0,    64'h0000_0000_8000_0000, 1, 7, 1, 64'h1000, 8'h00, 64'h0,               1, 1, 64'hFFFF_FFFF_FFFF_FF80, 0, 3);
    add_vec(1, 0, 3'b100, 64'h1003,   64'h0,                 64'h0,    64'h0000_0000_8000_0000, 1, 7, 1, 64'h1000, 8'h00, 64'h0,               1, 1, 64'h80,                 0, 3);
    add_vec(0, 1, 3'b001, 64'h2006,   64'hBEEF,              64'h0,    64'h0,                 1, 3, 1, 64'h2000, 8'hC0, 64'hBEEF_0000_0000_0000, 0, 0, 64'h0,              0, 3);
    add_vec(1, 0, 3'b011, 64'h4000,   64'h0,                 64'h0,    64'h0123_4567_89AB_CDEF, 1, 10, 1, 64'h4000, 8'h00, 64'h0,              1, 1, 64'h0123_4567_89AB_CDEF, 0, 3);
    add_vec(1, 0, 3'b010, 64'h4004,   64'h0,                 64'h0,    64'h8765_4321_0000_0000, 1, 11, 1, 64'h4000, 8'h00, 64'h0,              1, 1, 64'hFFFF_FFFF_8765_4321, 0, 3);
    add_vec(1, 0, 3'b110, 64'h4004,   64'h0,                 64'h0,    64'h8765_4321_0000_0000, 1, 11, 1, 64'h4000, 8'h00, 64'h0,              1, 1, 64'h0000_0000_8765_4321, 0, 3);
    add_vec(1, 0, 3'b001, 64'h4002,   64'h0,                 64'h0,    64'h0000_0000_F00D_0000, 1, 12, 1, 64'h4000, 8'h00, 64'h0,              1, 1, 64'hFFFF_FFFF_FFFF_F00D, 0, 3);
    add_vec(1, 0, 3'b101, 64'h4002,   64'h0,                 64'h0,    64'h0000_0000_F00D_0000, 1, 12, 1, 64'h4000, 8'h00, 64'h0,              1, 1, 64'h0000_0000_0000_F00D, 0, 3);
    add_vec(0, 1, 3'b011, 64'h5000,   64'h1122_3344_5566_7788, 64'h0,  64'h0,                 1, 3, 1, 64'h5000, 8'hFF, 64'h1122_3344_5566_7788, 0, 0, 64'h0,            0, 3);
    add_vec(0, 1, 3'b000, 64'h5005,   64'hAB,                64'h0,    64'h0,                 1, 3, 1, 64'h5000, 8'h20, 64'h0000_AB00_0000_0000, 0, 0, 64'h0,              0, 3);
    add_vec(0, 1, 3'b010, 64'h5004,   64'hDEAD_BEEF,         64'h0,    64'h0,                 1, 3, 1, 64'h5000, 8'hF0, 64'hDEAD_BEEF_0000_0000, 0, 0, 64'h0,              0, 3);
    add_vec(0, 0, 3'b000, 64'h0,      64'h0,                 64'h55,   64'h0,                 1, 0, 0, 64'h0,    8'h00, 64'h0,                 0, 1, 64'h55,                 0, 1);
    add_vec(0, 1, 3'b100, 64'h6000,   64'h0,                 64'h77,   64'h0,                 1, 4, 0, 64'h0,    8'h00, 64'h0,                 0, 1, 64'h77,                 0, 1);
    add_vec(1, 0, 3'b111, 64'h6000,   64'h0,                 64'h88,   64'h0,                 1, 4, 0, 64'h0,    8'h00, 64'h0,                 0, 1, 64'h88,                 0, 1);
    add_vec(1, 1, 3'b100, 64'h1003,   64'h0,                 64'h0,    64'h0000_0000_8000_0000, 1, 8, 1, 64'h1000, 8'h00, 64'h0,               1, 1, 64'h80,                 0, 3);
    add_vec(1, 0, 3'b011, 64'h4000,   64'h0,                 64'h0,    64'h0123_4567_89AB_CDEF, 0, 9, 1, 64'h4000, 8'h00, 64'h0,              0, 0, 64'h0,                  0, 3);
`ifdef MEM_MISALIGN_TRAP_EN
    add_vec(1, 0, 3'b010, 64'h3002,   64'h0,                 64'h0,    64'h1111_2222_CAFE_BABE, 1, 6, 0, 64'h0,    8'h00, 64'h0,              0, 0, 64'h0,                  1, 1);
`else
    add_vec(1, 0, 3'b010, 64'h3002,   64'h0,                 64'h0,    64'h1111_2222_CAFE_BABE, 1, 6, 1, 64'h3000, 8'h00, 64'h0,              1, 1, 64'hFFFF_FFFF_CAFE_BABE, 0, 3);
`endif

    for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

    // Stall: ready held low for five cycles, request must hold still.
    dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0;
    issue(0, 1, 3'b010, 64'h5004, 64'hDEAD_BEEF, 64'h0, 1, 3);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("stall%0d req_valid", i), 64'(dmem_req_valid), 64'd1);
      check($sformatf("stall%0d req_addr", i), dmem_req_addr, 64'h5000);
      check($sformatf("stall%0d req_wstrb", i), 64'(dmem_req_wstrb), 64'hF0);
      check($sformatf("stall%0d req_wdata", i), dmem_req_wdata, 64'hDEAD_BEEF_0000_0000);
      check($sformatf("stall%0d ex_ready", i), 64'(ex_ready), 64'd0);
      @(negedge clk);
    end
    dmem_req_ready = 1'b1;
    @(negedge clk);
    dmem_req_ready = 1'b0;
    check("stall wait req_valid", 64'(dmem_req_valid), 64'd0);
    check("stall wait ex_ready", 64'(ex_ready), 64'd0);
    dmem_rsp_valid = 1'b1;
    @(negedge clk);
    dmem_rsp_valid = 1'b0;
    check("stall wb_valid", 64'(wb_valid), 64'd1);
    check("stall wb_rd_w_ena", 64'(wb_rd_w_ena), 64'd0);
    check("stall wb_err", 64'(wb_err), 64'd0);
    @(negedge clk);
    check("stall ex_ready_after", 64'(ex_ready), 64'd1);

    // Timeout: WAIT entered at the edge after n=1, four WAIT cycles, wb at n=6.
    dmem_req_ready = 1'b1; dmem_rsp_valid = 1'b0;
    issue(1, 0, 3'b011, 64'h4000, 64'h0, 64'h0, 1, 12);
    first_wb = 0;
    for (int n = 1; n <= 12 && first_wb == 0; n++) begin
      if (wb_valid) begin
        first_wb = n;
        check("timeout wb_err", 64'(wb_err), 64'd1);
        check("timeout wb_rd_w_ena", 64'(wb_rd_w_ena), 64'd0);
      end else begin
        check($sformatf("timeout n%0d ex_ready", n), 64'(ex_ready), 64'd0);
        @(negedge clk);
      end
    end
    check("timeout latency", 64'(first_wb), 64'd6);
    dmem_req_ready = 1'b0;
    @(negedge clk);
    dmem_rsp_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("late_rsp%0d wb_valid", i), 64'(wb_valid), 64'd0);
    end
    dmem_rsp_valid = 1'b0;

    // Reset while a request is pending abandons it.
    issue(1, 0, 3'b011, 64'h4000, 64'h0, 64'h0, 1, 13);
    check("rst_mid req_valid_before", 64'(dmem_req_valid), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid req_valid", 64'(dmem_req_valid), 64'd0);
    check("rst_mid ex_ready", 64'(ex_ready), 64'd1);
    dmem_req_ready = 1'b1; dmem_rsp_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("rst_mid%0d wb_valid", i), 64'(wb_valid), 64'd0);
      check($sformatf("rst_mid%0d req_valid", i), 64'(dmem_req_valid), 64'd0);
    end
    dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage directly downstream of exe_stage in the rvcpu core; it consumes the ALU result and the load/store controls.
- Non-memory ops: registers the result through unchanged.
- Loads/stores: performs one valid/ready transaction on the data bus, with byte-lane alignment, strobes and load sign/zero extension.
- Presents a single-cycle writeback packet to the regfile write port; stalls upstream through ex_ready while a bus access is outstanding.

Parameters:
- XLEN, 64, register/data width; only 64 is supported (8 byte lanes).
- TIMEOUT_CYCLES, 256, WAIT-state cycles without a response before a bus error is declared; must be ≥2.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- ex_valid  in  1  exe packet valid
- ex_ready  out  1  stage can accept (state==IDLE)
- ex_load  in  1  load instruction
- ex_store  in  1  store instruction
- ex_funct3  in  3  RV64 load/store funct3
- ex_addr  in  64  effective address
- ex_wdata  in  64  store data (rs2)
- ex_alu_result  in  64  result for non-memory ops
- ex_rd_w_ena  in  1  destination write enable
- ex_rd_w_addr  in  5  destination register
- dmem_req_valid  out  1  bus request valid
- dmem_req_ready  in  1  bus accepts request
- dmem_req_addr  out  64  address, aligned to 8 bytes
- dmem_req_we  out  1  1=store
- dmem_req_wdata  out  64  lane-shifted store data
- dmem_req_wstrb  out  8  byte strobes
- dmem_rsp_valid  in  1  response valid (load data / store ack)
- dmem_rsp_rdata  in  64  raw 64-bit read data
- wb_valid  out  1  writeback packet valid, one cycle
- wb_rd_w_ena  out  1  regfile write enable
- wb_rd_w_addr  out  5  regfile write address
- wb_rd_data  out  64  regfile write data
- wb_err  out  1  bus timeout / misalign trap

Behaviour:
- Reset: state IDLE; all outputs 0 except ex_ready=1; counter cleared. Reset mid-transaction abandons it: dmem_req_valid=0 the next cycle, and any late dmem_rsp_valid is ignored.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE, on ex_valid:
  - Capture every ex_* input.
  - Non-memory op: go to RESP; wb_valid asserts the next cycle (latency 1) with wb_rd_data = ex_alu_result.
  - ex_load or ex_store: go to REQ.
  - ex_load and ex_store both high: treated as a load.
- REQ:
  - dmem_req_valid=1, all request fields stable until dmem_req_ready.
  - On the ready cycle go to WAIT and clear the counter.
- WAIT:
  - On dmem_rsp_valid: capture the extended data, go to RESP.
  - On counter == TIMEOUT_CYCLES-1 with no response: go to RESP with wb_err=1 and wb_rd_w_ena=0.
- RESP: wb_valid=1 for exactly one cycle, then IDLE. ex_ready=0 in REQ/WAIT/RESP.
- dmem_rsp_valid is ignored outside WAIT.
- Minimum load/store latency is 3 cycles (acceptance → wb_valid) with ready and rsp both immediate.
- Lane offset off = addr[2:0]. dmem_req_addr = {addr[63:3],3'b000}.
- Store:
  - Size mask by funct3: 000→0x01, 001→0x03, 010→0x0F, 011→0xFF.
  - wstrb = mask << off; wdata = ex_wdata << 8*off.
  - wb_rd_w_ena forced 0.
- Load:
  - d = rdata >> 8*off.
  - Result by funct3: LB/LH/LW sign-extend bits 7/15/31; LD = d; LBU/LHU/LWU zero-extend.
- wb_rd_w_ena = captured rd_w_ena & (rd_w_addr != 0) & !wb_err.
- Misaligned access: off not a multiple of the access size (e.g. LW with off=2, LD with off≠0).
- Undefined funct3 (store 1xx, load 111): no bus access, treated as a non-memory op with wb_rd_w_ena=0.

Optional Feature:
- MEM_MISALIGN_TRAP_EN defined: a misaligned access issues no bus transaction, goes IDLE→RESP, and raises wb_err=1 with wb_rd_w_ena=0.
- Not defined: the low address bits are cleared to the access size (naturally aligned), the access proceeds normally, and wb_err is driven only by a timeout.

Decomposition:
- defines.v holds:
  - load/store funct3 constants;
  - FSM state encodings (2-bit);
  - `MEM_STRB_BUS 7:0;
  - existing `REG_BUS.
- Natural combinational sub-module: mem_lane_align, which generates wstrb/wdata from (funct3, off, wdata) and extracts/extends load data from (funct3, off, rdata).

Test Plan:
- ADD passthrough: ex_valid, alu_result=0x1234, rd=5 → next cycle wb_valid=1, wb_rd_w_addr=5, wb_rd_data=0x1234, no dmem_req_valid.
- LB addr 0x1003, rdata=0x0000_0000_8000_0000 → req_addr 0x1000; wb_rd_data=0xFFFF_FFFF_FFFF_FF80; LBU gives 0x80.
- SH addr 0x2006, wdata=0xBEEF → wstrb=0xC0, wdata=0xBEEF_0000_0000_0000, we=1; wb_valid with wb_rd_w_ena=0.
- dmem_req_ready held low 5 cycles → request fields stable, ex_ready=0 throughout; completes after ready+rsp.
- No response, TIMEOUT_CYCLES=4 → wb_valid with wb_err=1 four cycles after entering WAIT; a later rsp_valid is ignored.
- LW addr 0x3002:
  - With MEM_MISALIGN_TRAP_EN: wb_err=1, no request.
  - Without it: req_addr 0x3000, data taken from lanes 0-3.
